// File: rtl/pong_pkg.sv
// pong_pkg: shared definitions for the Pong match sequencer slice.
//   - match FSM state encoding (also exported on the debug state port)
//   - screen limits used by the paddle/ball blocks
//   - score, frame-counter and move-divider widths
//   - saturating score increment helper
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_t;

  localparam int MAX_H   = 320;
  localparam int MAX_V   = 240;
  localparam int SCORE_W = 4;
  localparam int CNT_W   = 16;
  localparam int DIV_W   = 4;

  // Scores stick at all-ones instead of wrapping back to zero.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == '1) ? s : s + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// pong_frame_timer: loadable frame down-counter shared by the serve and
// point-pause delays.
// Ports:
//   clock, reset   system clock, synchronous active-high reset
//   i_load         load i_load_val (takes priority over a tick)
//   i_load_val     number of frame ticks to wait
//   i_tick         one-cycle frame pulse; decrements the count
//   o_done         high on the tick that brings the count to zero
module pong_frame_timer
  import pong_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_tick,
  output logic             o_done
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_tick && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  // Flags the final tick itself so the owner can act on the same edge.
  assign o_done = i_tick && (r_count <= CNT_W'(1));

endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencer for Pong. Rate-limits paddle buttons into
// one-cycle move requests, holds/launches the ball, keeps scores and walks
// the match through IDLE, SERVE, PLAY, POINT and OVER.
// Ports:
//   clock, reset                 system clock, synchronous active-high reset
//   i_frame_tick                 one-cycle pulse per video frame
//   i_start                      start button (level)
//   i_btn_{up,down}_{l,r}        paddle buttons (level)
//   i_ball_miss_{l,r}            ball passed left/right edge (pulse)
//   o_paddle_reset, o_ball_reset paddle / ball block resets
//   o_ball_launch                one-cycle launch pulse
//   o_serve_dir                  0 = serve left, 1 = serve right
//   o_{up,down}_{l,r}            one-cycle paddle move requests
//   o_score_l, o_score_r         scores
//   o_winner_valid, o_winner     match result (0 = left won)
//   o_state                      encoded FSM state
// All outputs are registered.
module pong_match_ctrl
  import pong_pkg::*;
#(
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int WIN_SCORE    = 7,
  parameter int MOVE_DIV     = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               i_frame_tick,
  input  logic               i_start,
  input  logic               i_btn_up_l,
  input  logic               i_btn_down_l,
  input  logic               i_btn_up_r,
  input  logic               i_btn_down_r,
  input  logic               i_ball_miss_l,
  input  logic               i_ball_miss_r,
  output logic               o_paddle_reset,
  output logic               o_ball_reset,
  output logic               o_ball_launch,
  output logic               o_serve_dir,
  output logic               o_up_l,
  output logic               o_down_l,
  output logic               o_up_r,
  output logic               o_down_r,
  output logic [SCORE_W-1:0] o_score_l,
  output logic [SCORE_W-1:0] o_score_r,
  output logic               o_winner_valid,
  output logic               o_winner,
  output logic [2:0]         o_state
);

  localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

  state_t             r_state, w_state_next;
  logic [SCORE_W-1:0] r_score_l, r_score_r, w_score_l_next, w_score_r_next;
  logic [DIV_W-1:0]   r_div, w_div_next;
  logic               r_paddle_reset, r_ball_reset, r_ball_launch, r_serve_dir;
  logic               r_up_l, r_down_l, r_up_r, r_down_r;
  logic               r_winner_valid, r_winner;
  logic               w_paddle_reset_next, w_ball_launch_next, w_serve_dir_next;
  logic               w_winner_next, w_move_en, w_div_wrap, w_miss_play;
  logic               w_timer_load, w_timer_done;
  logic [CNT_W-1:0]   w_timer_val;

  pong_frame_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_timer_load),
    .i_load_val (w_timer_val),
    .i_tick     (i_frame_tick),
    .o_done     (w_timer_done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_score_l      <= '0;
      r_score_r      <= '0;
      r_div          <= '0;
      r_paddle_reset <= 1'b1;
      r_ball_reset   <= 1'b1;
      r_ball_launch  <= 1'b0;
      r_serve_dir    <= 1'b1;
      r_up_l         <= 1'b0;
      r_down_l       <= 1'b0;
      r_up_r         <= 1'b0;
      r_down_r       <= 1'b0;
      r_winner_valid <= 1'b0;
      r_winner       <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_score_l      <= w_score_l_next;
      r_score_r      <= w_score_r_next;
      r_div          <= w_div_next;
      r_paddle_reset <= w_paddle_reset_next;
      r_ball_reset   <= (w_state_next != ST_PLAY);
      r_ball_launch  <= w_ball_launch_next;
      r_serve_dir    <= w_serve_dir_next;
      r_up_l         <= w_move_en & i_btn_up_l & ~i_btn_down_l;
      r_down_l       <= w_move_en & i_btn_down_l & ~i_btn_up_l;
      r_up_r         <= w_move_en & i_btn_up_r & ~i_btn_down_r;
      r_down_r       <= w_move_en & i_btn_down_r & ~i_btn_up_r;
      r_winner_valid <= (w_state_next == ST_OVER);
      r_winner       <= w_winner_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_score_l_next     = r_score_l;
    w_score_r_next     = r_score_r;
    w_serve_dir_next   = r_serve_dir;
    w_winner_next      = r_winner;
    w_ball_launch_next = 1'b0;
    w_miss_play        = 1'b0;
    w_timer_load       = 1'b0;
    w_timer_val        = CNT_W'(SERVE_FRAMES);

    // Free-running divider: moves are granted on every MOVE_DIV-th tick.
    w_div_wrap = (r_div == DIV_W'(MOVE_DIV - 1));
    w_div_next = r_div;
    if (i_frame_tick) begin
      w_div_next = w_div_wrap ? '0 : r_div + DIV_W'(1);
    end
    w_move_en = i_frame_tick & w_div_wrap &
                ((r_state == ST_SERVE) || (r_state == ST_PLAY));

    case (r_state)
      ST_IDLE, ST_OVER: begin
        if (i_start) begin
          w_state_next   = ST_SERVE;
          w_score_l_next = '0;
          w_score_r_next = '0;
          w_timer_load   = 1'b1;
        end
      end
      ST_SERVE: begin
        if (w_timer_done) begin
          w_state_next       = ST_PLAY;
          w_ball_launch_next = 1'b1;
        end
      end
      ST_PLAY: begin
        if (i_ball_miss_l || i_ball_miss_r) begin
          w_miss_play  = 1'b1;
          w_state_next = ST_POINT;
          w_timer_load = 1'b1;
          w_timer_val  = CNT_W'(POINT_FRAMES);
          // A simultaneous double miss is a void rally.
          if (i_ball_miss_l && !i_ball_miss_r) begin
            w_score_r_next   = score_inc(r_score_r);
            w_serve_dir_next = 1'b0;
          end else if (i_ball_miss_r && !i_ball_miss_l) begin
            w_score_l_next   = score_inc(r_score_l);
            w_serve_dir_next = 1'b1;
          end
        end
      end
      ST_POINT: begin
        if (w_timer_done) begin
          if ((r_score_l == WIN_VAL) || (r_score_r == WIN_VAL)) begin
            w_state_next  = ST_OVER;
            w_winner_next = (r_score_r == WIN_VAL);
          end else begin
            w_state_next = ST_SERVE;
            w_timer_load = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    w_paddle_reset_next = (w_state_next == ST_IDLE) || (w_state_next == ST_OVER) ||
                          w_miss_play;
  end

  assign o_state        = r_state;
  assign o_score_l      = r_score_l;
  assign o_score_r      = r_score_r;
  assign o_paddle_reset = r_paddle_reset;
  assign o_ball_reset   = r_ball_reset;
  assign o_ball_launch  = r_ball_launch;
  assign o_serve_dir    = r_serve_dir;
  assign o_up_l         = r_up_l;
  assign o_down_l       = r_down_l;
  assign o_up_r         = r_up_r;
  assign o_down_r       = r_down_r;
  assign o_winner_valid = r_winner_valid;
  assign o_winner       = r_winner;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// tb_pong_match_ctrl: directed walk through a full match followed by random
// stimulus, every cycle compared against a frame/score-level model.
module tb_pong_match_ctrl;

  localparam int SERVE_F = 3;
  localparam int POINT_F = 4;
  localparam int WIN     = 2;
  localparam int DIV     = 2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic frame_tick = 1'b0, start = 1'b0;
  logic bul = 1'b0, bdl = 1'b0, bur = 1'b0, bdr = 1'b0;
  logic miss_l = 1'b0, miss_r = 1'b0;

  logic       o_paddle_reset, o_ball_reset, o_ball_launch, o_serve_dir;
  logic       o_up_l, o_down_l, o_up_r, o_down_r;
  logic [3:0] o_score_l, o_score_r;
  logic       o_winner_valid, o_winner;
  logic [2:0] o_state;

  pong_match_ctrl #(
    .SERVE_FRAMES (SERVE_F),
    .POINT_FRAMES (POINT_F),
    .WIN_SCORE    (WIN),
    .MOVE_DIV     (DIV)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .i_frame_tick   (frame_tick),
    .i_start        (start),
    .i_btn_up_l     (bul),
    .i_btn_down_l   (bdl),
    .i_btn_up_r     (bur),
    .i_btn_down_r   (bdr),
    .i_ball_miss_l  (miss_l),
    .i_ball_miss_r  (miss_r),
    .o_paddle_reset (o_paddle_reset),
    .o_ball_reset   (o_ball_reset),
    .o_ball_launch  (o_ball_launch),
    .o_serve_dir    (o_serve_dir),
    .o_up_l         (o_up_l),
    .o_down_l       (o_down_l),
    .o_up_r         (o_up_r),
    .o_down_r       (o_down_r),
    .o_score_l      (o_score_l),
    .o_score_r      (o_score_r),
    .o_winner_valid (o_winner_valid),
    .o_winner       (o_winner),
    .o_state        (o_state)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;
  int cnt_up_l = 0;

  // Model: phase number, scores, frames left in the current delay, and the
  // total frame ticks seen since reset (moves granted on multiples of DIV).
  int m_state, m_sl, m_sr, m_left, m_ticks;
  int m_dir, m_winner, m_wv, m_launch, m_prst, m_brst;
  int m_up_l, m_down_l, m_up_r, m_down_r;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_update();
    int ns;
    int miss_play;
    if (reset) begin
      m_state = 0; m_sl = 0; m_sr = 0; m_left = 0; m_ticks = 0;
      m_dir = 1; m_winner = 0; m_wv = 0; m_launch = 0; m_prst = 1; m_brst = 1;
      m_up_l = 0; m_down_l = 0; m_up_r = 0; m_down_r = 0;
      return;
    end
    m_launch = 0;
    m_up_l = 0; m_down_l = 0; m_up_r = 0; m_down_r = 0;
    if (frame_tick) begin
      m_ticks++;
      if ((m_state == 1 || m_state == 2) && (m_ticks % DIV == 0)) begin
        m_up_l   = int'(bul && !bdl);
        m_down_l = int'(bdl && !bul);
        m_up_r   = int'(bur && !bdr);
        m_down_r = int'(bdr && !bur);
      end
    end
    ns = m_state;
    miss_play = 0;
    case (m_state)
      0, 4: if (start) begin
        ns = 1; m_sl = 0; m_sr = 0; m_left = SERVE_F;
      end
      1: if (frame_tick) begin
        m_left--;
        if (m_left == 0) begin ns = 2; m_launch = 1; end
      end
      2: if (miss_l || miss_r) begin
        miss_play = 1; ns = 3; m_left = POINT_F;
        if (miss_l && !miss_r) begin
          m_sr = (m_sr < 15) ? m_sr + 1 : 15; m_dir = 0;
        end else if (miss_r && !miss_l) begin
          m_sl = (m_sl < 15) ? m_sl + 1 : 15; m_dir = 1;
        end
      end
      3: if (frame_tick) begin
        m_left--;
        if (m_left == 0) begin
          if (m_sl == WIN || m_sr == WIN) begin
            ns = 4; m_winner = int'(m_sr == WIN);
          end else begin
            ns = 1; m_left = SERVE_F;
          end
        end
      end
      default: ns = 0;
    endcase
    m_state = ns;
    m_prst = int'(ns == 0 || ns == 4 || miss_play == 1);
    m_brst = int'(ns != 2);
    m_wv   = int'(ns == 4);
  endtask

  task automatic check_all();
    chk("state",        8'(o_state),        8'(m_state));
    chk("score_l",      8'(o_score_l),      8'(m_sl));
    chk("score_r",      8'(o_score_r),      8'(m_sr));
    chk("serve_dir",    8'(o_serve_dir),    8'(m_dir));
    chk("ball_launch",  8'(o_ball_launch),  8'(m_launch));
    chk("paddle_reset", 8'(o_paddle_reset), 8'(m_prst));
    chk("ball_reset",   8'(o_ball_reset),   8'(m_brst));
    chk("winner_valid", 8'(o_winner_valid), 8'(m_wv));
    chk("winner",       8'(o_winner),       8'(m_winner));
    chk("moves",        8'({o_up_l, o_down_l, o_up_r, o_down_r}),
        8'({m_up_l[0], m_down_l[0], m_up_r[0], m_down_r[0]}));
    if (o_up_l) cnt_up_l++;
  endtask

  task automatic clk_step();
    model_update();
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic tick_pulse();
    frame_tick = 1'b1;
    clk_step();
    frame_tick = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_pulse();
      clk_step();
    end
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    clk_step();
    clk_step();
    chk("rst_state",        8'(o_state),        8'd0);
    chk("rst_paddle_reset", 8'(o_paddle_reset), 8'd1);
    chk("rst_ball_reset",   8'(o_ball_reset),   8'd1);
    chk("rst_serve_dir",    8'(o_serve_dir),    8'd1);
    reset = 1'b0;
    clk_step();

    // Start, then serve delay of SERVE_F ticks
    start = 1'b1;
    clk_step();
    start = 1'b0;
    chk("start_to_serve", 8'(o_state), 8'd1);
    for (int i = 0; i < SERVE_F; i++) begin
      tick_pulse();
      if (i < SERVE_F - 1) begin
        chk("serve_hold", 8'(o_ball_launch), 8'd0);
        clk_step();
      end
    end
    chk("launch_pulse", 8'(o_ball_launch), 8'd1);
    chk("launch_state", 8'(o_state),       8'd2);
    clk_step();
    chk("launch_one_cycle", 8'(o_ball_launch), 8'd0);

    // Move gating with DIV=2
    bul = 1'b1;
    cnt_up_l = 0;
    run_ticks(6);
    chk("up_l_div_count", 8'(cnt_up_l), 8'd3);
    bdl = 1'b1;
    cnt_up_l = 0;
    run_ticks(6);
    chk("up_l_opposed_count", 8'(cnt_up_l), 8'd0);
    bul = 1'b0;
    bdl = 1'b0;

    // Right miss: left scores
    miss_r = 1'b1;
    clk_step();
    miss_r = 1'b0;
    chk("miss_r_score_l",  8'(o_score_l),      8'd1);
    chk("miss_r_dir",      8'(o_serve_dir),    8'd1);
    chk("miss_r_prst",     8'(o_paddle_reset), 8'd1);
    chk("miss_r_state",    8'(o_state),        8'd3);
    clk_step();
    chk("prst_one_cycle",  8'(o_paddle_reset), 8'd0);
    run_ticks(POINT_F);
    chk("point_to_serve",  8'(o_state),        8'd1);

    // Double miss: void rally
    run_ticks(SERVE_F);
    miss_l = 1'b1;
    miss_r = 1'b1;
    clk_step();
    miss_l = 1'b0;
    miss_r = 1'b0;
    chk("dbl_score_l", 8'(o_score_l), 8'd1);
    chk("dbl_score_r", 8'(o_score_r), 8'd0);
    chk("dbl_state",   8'(o_state),   8'd3);
    run_ticks(POINT_F);

    // Second right miss wins the match for the left player
    run_ticks(SERVE_F);
    miss_r = 1'b1;
    clk_step();
    miss_r = 1'b0;
    chk("win_score_l", 8'(o_score_l), 8'd2);
    run_ticks(POINT_F);
    chk("over_state",        8'(o_state),        8'd4);
    chk("over_winner_valid", 8'(o_winner_valid), 8'd1);
    chk("over_winner",       8'(o_winner),       8'd0);
    start = 1'b1;
    clk_step();
    start = 1'b0;
    chk("restart_state",   8'(o_state),   8'd1);
    chk("restart_score_l", 8'(o_score_l), 8'd0);

    // Reset in the middle of SERVE after a point
    run_ticks(SERVE_F);
    miss_l = 1'b1;
    clk_step();
    miss_l = 1'b0;
    chk("miss_l_score_r", 8'(o_score_r),   8'd1);
    chk("miss_l_dir",     8'(o_serve_dir), 8'd0);
    run_ticks(POINT_F);
    run_ticks(1);
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    chk("midrst_state",   8'(o_state),        8'd0);
    chk("midrst_score_r", 8'(o_score_r),      8'd0);
    chk("midrst_prst",    8'(o_paddle_reset), 8'd1);

    // Random phase
    for (int c = 0; c < 3000; c++) begin
      frame_tick = ($urandom_range(3) == 0);
      start      = ($urandom_range(30) == 0);
      miss_l     = ($urandom_range(15) == 0);
      miss_r     = ($urandom_range(15) == 0);
      bul        = 1'($urandom_range(1));
      bdl        = 1'($urandom_range(1));
      bur        = 1'($urandom_range(1));
      bdr        = 1'($urandom_range(1));
      reset      = ($urandom_range(500) == 0);
      clk_step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the Pong game. Sits above the two paddle blocks and the ball block: it turns raw player buttons into rate-limited, one-cycle paddle move requests, resets and launches the ball, keeps both scores, and walks the match through serve, play, point and game-over phases. All pixel motion happens in the paddle/ball blocks; this block owns only timing, gating and scoring.

## Interface
Parameters:
- SERVE_FRAMES, 60: frames the ball is held at centre before launch.
- POINT_FRAMES, 90: frames of pause after a point is scored.
- WIN_SCORE, 7: score that ends the match; legal range 1..15.
- MOVE_DIV, 1: paddle moves once per MOVE_DIV frames; legal range 1..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  level; player start button, already synchronised.
- btn_up_l, btn_down_l, btn_up_r, btn_down_r  in  1 each  level; player buttons, already synchronised.
- ball_miss_l, ball_miss_r  in  1 each  one-cycle pulse; ball passed the left or right edge.
- paddle_reset  out  1  drives reset of both paddle blocks.
- ball_reset  out  1  holds the ball at centre.
- ball_launch  out  1  one-cycle pulse; the ball starts moving.
- serve_dir  out  1  0 = serve toward left, 1 = toward right.
- up_l, down_l, up_r, down_r  out  1 each  one-cycle paddle move requests.
- score_l, score_r  out  4 each  current scores.
- winner_valid  out  1  high in GAME_OVER.
- winner  out  1  0 = left won, 1 = right won.
- state  out  3  encoded FSM state, for debug and display.

## Operation
States: IDLE(0), SERVE(1), PLAY(2), POINT(3), OVER(4).
- IDLE: paddle_reset=1, ball_reset=1, no move pulses. start=1 → SERVE; scores cleared; frame counter loaded with SERVE_FRAMES.
- SERVE: ball_reset=1; paddles movable. Counter decrements on each frame_tick. On reaching 0: ball_launch pulses, state → PLAY.
- PLAY: ball_reset=0; paddles movable.
  - ball_miss_l alone: score_r+1, serve_dir←0.
  - ball_miss_r alone: score_l+1, serve_dir←1.
  - Both misses in the same cycle: no score change, serve_dir unchanged.
  - Any miss → POINT; counter loaded with POINT_FRAMES; paddle_reset pulses for one cycle.
- POINT: ball_reset=1; no move pulses; misses ignored. On counter 0: if either score equals WIN_SCORE → OVER, else → SERVE with counter loaded with SERVE_FRAMES.
- OVER: winner_valid=1 and winner held; ball_reset=1; paddle_reset=1. start=1 → SERVE; scores cleared.
- Move gating, in SERVE and PLAY only: a 4-bit divider counts frame_ticks. On the frame_tick where the divider wraps (every MOVE_DIV ticks), up_x = btn_up_x & ~btn_down_x and down_x = btn_down_x & ~btn_up_x for one cycle. Opposing buttons both pressed → no move.
- Scores saturate at 15. Misses outside PLAY are ignored.
- serve_dir reset value is 1.

## Timing
- All outputs are registered and change on the clock edge after the causing input.
- Move pulse: 1 cycle after the qualifying frame_tick.
- SERVE entry to ball_launch: exactly SERVE_FRAMES frame_ticks. ball_launch fires 1 cycle after the last tick, in the same cycle that state becomes PLAY.
- Score update, POINT entry and paddle_reset pulse all occur 1 cycle after the miss pulse.
- Reset values: state=IDLE; scores=0; ball_launch=0; all move pulses=0; paddle_reset=1; ball_reset=1; winner_valid=0; winner=0; serve_dir=1; divider=0; frame counter=0.
- reset mid-match: returns to IDLE on the next edge; all counters and scores cleared.
- start held continuously: only evaluated in IDLE and OVER, so it cannot restart a running match.

## Structure
- Shared package pong_pkg holds:
  - the state encoding constants;
  - screen limits MAX_H=320, MAX_V=240;
  - the score width (4).
- One sub-module, pong_frame_timer: loadable down-counter decremented by frame_tick, with a done flag. Instantiated once and reused for the SERVE and POINT delays.

## Test plan
- Reset, then start=1 for one cycle → SERVE. With SERVE_FRAMES=3: ball_launch pulses 1 cycle after the 3rd frame_tick, and state=2.
- PLAY, btn_up_l=1, MOVE_DIV=2, 6 frame_ticks → exactly 3 up_l pulses. With btn_up_l=btn_down_l=1 → no pulses.
- PLAY, ball_miss_r pulse → score_l=1, serve_dir=1, paddle_reset pulse, state=3. After POINT_FRAMES ticks → state=1.
- PLAY, ball_miss_l and ball_miss_r in the same cycle → scores unchanged, state=3.
- WIN_SCORE=2: two right misses → after POINT, state=4, winner_valid=1, winner=0. Then start → scores 0, state=1.
- Assert reset during SERVE with counter mid-way → next cycle state=0, scores 0, paddle_reset=1.
